// File: rtl/fc_pass_ctrl_if.sv
// Handshake bundle between fc_pass_ctrl and the ibuf / CIM tile / function unit.
// master = controller side; slave = the surrounding datapath.
interface fc_pass_ctrl_if #(
    parameter int COUNT_WIDTH = 3,
    parameter int PASS_WIDTH  = 1,
    parameter int ADDR_WIDTH  = 3
);
    logic                   i_start;
    logic                   o_ready;
    logic [COUNT_WIDTH-1:0] o_count;
    logic [PASS_WIDTH-1:0]  o_pass;
    logic                   i_cim_ready;
    logic                   o_cim_we;
    logic                   o_cim_start;
    logic [ADDR_WIDTH-1:0]  o_addr;
    logic                   i_func_ready;
    logic                   o_func_start;

    modport master (
        input  i_start, i_cim_ready, i_func_ready,
        output o_ready, o_count, o_pass, o_cim_we, o_cim_start, o_addr, o_func_start
    );

    modport slave (
        output i_start, i_cim_ready, i_func_ready,
        input  o_ready, o_count, o_pass, o_cim_we, o_cim_start, o_addr, o_func_start
    );
endinterface

// File: rtl/fc_pass_ctrl.sv
// Counts pixel pulses into a full image, then streams DATA_SIZE bit-planes x PASSES weight sets into the CIM.
// First CIM write 1 cycle after the last pixel (or after i_cim_ready rises); stalls on CIM / function-unit ready.
module fc_pass_ctrl #(
    parameter int DATA_SIZE      = 8,
    parameter int INPUT_CHANNELS = 16,
    parameter int IMG_SIZE       = 784,
    parameter int XBAR_SIZE      = 128,
    parameter int BUS_WIDTH      = 16,
    parameter int PASSES         = 1,
    parameter int V_CIM_TILES    = (INPUT_CHANNELS * IMG_SIZE + XBAR_SIZE - 1) / XBAR_SIZE,
    parameter int NUM_ADDR       = (INPUT_CHANNELS * IMG_SIZE + BUS_WIDTH * V_CIM_TILES - 1)
                                   / (BUS_WIDTH * V_CIM_TILES),
    parameter int ADDR_WIDTH     = (NUM_ADDR > 1)  ? $clog2(NUM_ADDR)  : 1,
    parameter int COUNT_WIDTH    = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1,
    parameter int PASS_WIDTH     = (PASSES > 1)    ? $clog2(PASSES)    : 1
) (
    input  logic           clk,
    input  logic           rst,
    fc_pass_ctrl_if.master io_fc
);
    localparam int PIX_WIDTH = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;

    localparam logic [PIX_WIDTH-1:0]   PIX_LAST  = PIX_WIDTH'(IMG_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0]  ADDR_LAST = ADDR_WIDTH'(NUM_ADDR - 1);
    localparam logic [COUNT_WIDTH-1:0] BIT_LAST  = COUNT_WIDTH'(DATA_SIZE - 1);
    localparam logic [PASS_WIDTH-1:0]  PASS_LAST = PASS_WIDTH'(PASSES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_CONSUME,
        S_START,
        S_WAIT,
        S_FUNC
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [PIX_WIDTH-1:0]   r_pix_cnt;
    logic [PIX_WIDTH-1:0]   w_pix_nxt;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [ADDR_WIDTH-1:0]  w_addr_nxt;
    logic [COUNT_WIDTH-1:0] r_bit;
    logic [COUNT_WIDTH-1:0] w_bit_nxt;
    logic [PASS_WIDTH-1:0]  r_pass;
    logic [PASS_WIDTH-1:0]  w_pass_nxt;
    logic                   w_cim_start;
    logic                   w_func_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pix_cnt <= '0;
            r_addr    <= '0;
            r_bit     <= '0;
            r_pass    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pix_cnt <= w_pix_nxt;
            r_addr    <= w_addr_nxt;
            r_bit     <= w_bit_nxt;
            r_pass    <= w_pass_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pix_nxt    = r_pix_cnt;
        w_addr_nxt   = r_addr;
        w_bit_nxt    = r_bit;
        w_pass_nxt   = r_pass;
        w_cim_start  = 1'b0;
        w_func_start = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (io_fc.i_start) begin
                    if (r_pix_cnt == PIX_LAST) begin
                        w_pix_nxt   = '0;
                        w_state_nxt = io_fc.i_cim_ready ? S_CONSUME : S_ARM;
                    end else begin
                        w_pix_nxt = r_pix_cnt + PIX_WIDTH'(1);
                    end
                end
            end
            S_ARM: begin
                if (io_fc.i_cim_ready) begin
                    w_state_nxt = S_CONSUME;
                end
            end
            S_CONSUME: begin
                if (r_addr == ADDR_LAST) begin
                    w_addr_nxt  = '0;
                    w_state_nxt = S_START;
                end else begin
                    w_addr_nxt = r_addr + ADDR_WIDTH'(1);
                end
            end
            S_START: begin
                // Start is held until the CIM acknowledges by dropping ready.
                w_cim_start = io_fc.i_cim_ready;
                if (!io_fc.i_cim_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (io_fc.i_cim_ready) begin
                    if (r_bit != BIT_LAST) begin
                        w_bit_nxt   = r_bit + COUNT_WIDTH'(1);
                        w_state_nxt = S_CONSUME;
                    end else if (r_pass != PASS_LAST) begin
                        w_bit_nxt   = '0;
                        w_pass_nxt  = r_pass + PASS_WIDTH'(1);
                        w_state_nxt = S_CONSUME;
                    end else begin
                        w_state_nxt = S_FUNC;
                    end
                end
            end
            S_FUNC: begin
                w_func_start = io_fc.i_func_ready;
                if (io_fc.i_func_ready) begin
                    w_bit_nxt   = '0;
                    w_pass_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign io_fc.o_ready      = (r_state == S_IDLE);
    assign io_fc.o_cim_we     = (r_state == S_CONSUME);
    assign io_fc.o_addr       = r_addr;
    assign io_fc.o_count      = r_bit;
    assign io_fc.o_pass       = r_pass;
    assign io_fc.o_cim_start  = w_cim_start;
    assign io_fc.o_func_start = w_func_start;

endmodule

// File: tb/tb_fc_pass_ctrl.sv
// Bench for fc_pass_ctrl: directed scenarios plus randomized images against a transaction-level model
// (expected write stream, start/hand-off rules) with a small CIM / function-unit responder.
module tb_fc_pass_ctrl;
    localparam int DATA_SIZE      = 2;
    localparam int INPUT_CHANNELS = 8;
    localparam int IMG_SIZE       = 3;
    localparam int XBAR_SIZE      = 32;
    localparam int BUS_WIDTH      = 6;
    localparam int PASSES         = 2;
    localparam int NUM_ADDR       = 4;

    typedef struct {
        int addr;
        int cnt;
        int pas;
    } wr_t;

    logic clk;
    logic rst;

    fc_pass_ctrl_if #(.COUNT_WIDTH(1), .PASS_WIDTH(1), .ADDR_WIDTH(2)) fc_if ();

    fc_pass_ctrl #(
        .DATA_SIZE      (DATA_SIZE),
        .INPUT_CHANNELS (INPUT_CHANNELS),
        .IMG_SIZE       (IMG_SIZE),
        .XBAR_SIZE      (XBAR_SIZE),
        .BUS_WIDTH      (BUS_WIDTH),
        .PASSES         (PASSES)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .io_fc (fc_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_cmp = 0;
    int  n_bad = 0;

    // Reference model state
    wr_t exp_q[$];
    bit  chk_en = 0;
    bit  m_active = 0, m_arm = 0, m_we_next = 0;
    int  m_pix = 0, runs = 0, wr_plane = 0, img_wr = 0, img_trig = 0, fs_cnt = 0;
    bit  rst_prev = 0, cs_prev = 0, frdy_prev = 1;
    int  cs_len = 0;
    // CIM / function-unit responder
    int  busy = 0, hold = 0, fall_delay = 1, busy_len = 2, cim_block = 0, func_block = 0;
    bit  fs_plan = 0, fs_watch = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle(input bit st, input bit do_rst);
        bit  act, crdy, frdy, cs, fs, we, hold_fs;
        wr_t w;
        hold_fs = 0;
        rst = do_rst;
        fc_if.i_start = st;
        crdy = (busy == 0) && (cim_block == 0);
        frdy = (func_block == 0);
        fc_if.i_cim_ready  = crdy;
        fc_if.i_func_ready = frdy;
        #1;
        cs = fc_if.o_cim_start;
        fs = fc_if.o_func_start;
        we = fc_if.o_cim_we;
        if (chk_en) begin
            if (rst_prev) begin
                check_eq("rst_count", int'(fc_if.o_count), 0);
                check_eq("rst_pass", int'(fc_if.o_pass), 0);
                check_eq("rst_addr", int'(fc_if.o_addr), 0);
                check_eq("rst_we", int'(we), 0);
                check_eq("rst_cim_start", int'(cs), 0);
                check_eq("rst_func_start", int'(fs), 0);
            end
            check_eq("ready", int'(fc_if.o_ready), int'(!m_active));
            if (m_we_next) check_eq("first_we_latency", int'(we), 1);
            else if (m_arm) check_eq("arm_no_we", int'(we), 0);
            if (we) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_we", int'(we), 0);
                end else begin
                    w = exp_q.pop_front();
                    check_eq("we_addr", int'(fc_if.o_addr), w.addr);
                    check_eq("we_count", int'(fc_if.o_count), w.cnt);
                    check_eq("we_pass", int'(fc_if.o_pass), w.pas);
                    wr_plane++;
                    img_wr++;
                    if (exp_q.size() == 0 && fs_plan) hold_fs = 1;
                end
            end
            if (cs) check_eq("cim_start_needs_ready", int'(crdy), 1);
            if (cs && !cs_prev) begin
                check_eq("cim_start_plane_len", wr_plane, NUM_ADDR);
                check_eq("cim_start_active", int'(m_active), 1);
                runs++;
                wr_plane = 0;
            end
            if (!cs && cs_prev) check_eq("cim_start_hold", cs_len, fall_delay);
            if (fs_watch && frdy && !frdy_prev) begin
                check_eq("func_start_on_release", int'(fs), 1);
                fs_watch = 0;
            end
            if (fs) begin
                check_eq("func_start_active", int'(m_active), 1);
                check_eq("func_start_ready", int'(frdy), 1);
                check_eq("func_start_runs", runs, DATA_SIZE * PASSES);
                check_eq("func_start_drained", exp_q.size(), 0);
                fs_cnt++;
            end
        end

        act = m_active;
        m_we_next = 0;
        if (do_rst) begin
            m_active = 0; m_arm = 0; m_pix = 0; exp_q.delete();
            runs = 0; wr_plane = 0; img_wr = 0;
            busy = 0; hold = 0; cim_block = 0; func_block = 0; fs_watch = 0;
        end else begin
            if (fs) begin
                m_active = 0;
                runs = 0;
            end
            if (st && !act) begin
                m_pix++;
                if (m_pix == IMG_SIZE) begin
                    m_pix = 0; m_active = 1; img_trig++; img_wr = 0; wr_plane = 0;
                    for (int p = 0; p < PASSES; p++)
                        for (int b = 0; b < DATA_SIZE; b++)
                            for (int a = 0; a < NUM_ADDR; a++)
                                exp_q.push_back('{addr: a, cnt: b, pas: p});
                    if (crdy) m_we_next = 1;
                    else m_arm = 1;
                end
            end else if (m_arm && crdy) begin
                m_arm = 0;
                m_we_next = 1;
            end
            if (cs) begin
                hold++;
                if (hold >= fall_delay) begin
                    busy = busy_len;
                    hold = 0;
                end
            end else if (busy > 0) begin
                busy--;
            end
            if (cim_block > 0) cim_block--;
            if (func_block > 0) func_block--;
            if (hold_fs) begin
                func_block = 8;
                fs_watch = 1;
            end
        end
        rst_prev  = do_rst;
        cs_len    = cs ? cs_len + 1 : 0;
        cs_prev   = cs;
        frdy_prev = frdy;
        @(posedge clk);
        #1;
    endtask

    task automatic send_image();
        for (int i = 0; i < IMG_SIZE; i++) cycle(1, 0);
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (m_active && n < budget) begin
            cycle(0, 0);
            n++;
        end
        if (m_active) check_eq("idle_timeout", int'(fc_if.o_ready), 1);
        cycle(0, 0);
        cycle(0, 0);
    endtask

    initial begin
        int fs_base, bound;
        bit st;
        rst = 1'b1;
        fc_if.i_start = 1'b0;
        fc_if.i_cim_ready = 1'b1;
        fc_if.i_func_ready = 1'b1;
        @(posedge clk);
        #1;
        cycle(0, 1);
        cycle(0, 1);
        chk_en = 1;

        // 1: full image, CIM busy 2 cycles per run
        cycle(0, 0);
        send_image();
        run_until_idle(200);
        check_eq("s1_func_once", fs_cnt, 1);

        // 2: partial image stays idle, third pulse triggers
        cycle(1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0);
        cycle(1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0);
        cycle(1, 0);
        run_until_idle(200);
        check_eq("s2_func_once", fs_cnt, 2);

        // 3: CIM not ready at trigger for 5 cycles, extra pulses in ARM
        cycle(1, 0);
        cycle(1, 0);
        cim_block = 5;
        cycle(1, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0);
        run_until_idle(200);
        check_eq("s3_func_once", fs_cnt, 3);

        // 4: function unit busy at the end
        fs_plan = 1;
        send_image();
        run_until_idle(200);
        fs_plan = 0;
        check_eq("s4_func_once", fs_cnt, 4);

        // 5: reset in the middle of the second bit-plane
        send_image();
        bound = 0;
        while (img_wr < NUM_ADDR + 2 && bound < 100) begin
            cycle(0, 0);
            bound++;
        end
        check_eq("s5_reached_plane2", img_wr, NUM_ADDR + 2);
        cycle(0, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0);
        check_eq("s5_no_func_start", fs_cnt, 4);
        send_image();
        run_until_idle(200);
        check_eq("s5_func_once", fs_cnt, 5);

        // 6: CIM acknowledges start 3 cycles late
        fall_delay = 3;
        send_image();
        run_until_idle(200);
        fall_delay = 1;
        check_eq("s6_func_once", fs_cnt, 6);

        // Randomized traffic
        fs_base = fs_cnt;
        img_trig = 0;
        for (int n = 0; n < 4000 && img_trig < 20; n++) begin
            st = ($urandom_range(0, 2) == 0);
            if (!m_active && busy == 0 && hold == 0) begin
                fall_delay = $urandom_range(1, 3);
                busy_len   = $urandom_range(1, 3);
            end
            if (st && !m_active && m_pix == IMG_SIZE - 1) begin
                cim_block  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 5) : 0;
                func_block = $urandom_range(0, 12);
            end
            cycle(st, 0);
        end
        run_until_idle(300);
        check_eq("rand_func_per_image", fs_cnt - fs_base, img_trig);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
